// File: rtl/euclid_host_master.sv
// euclid_host_master: Avalon-MM master that runs one job on the Euclid-distance accelerator.
// A job is 4*VECTOR_SIZE coordinate words (x1,x2,y1,y2 per vector, vector 0 first) taken from
// the input stream. Each word is written to the slave register file, then CTRL is set to 1.
// The block then waits for done_irq and reads back VECTOR_SIZE results, which are sent out on
// the result stream. It writes CTRL=0 after every job and after a timeout.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready/in_data        coordinate word stream (input)
//   out_valid/out_ready/out_data     result word stream (output), out_last marks the final word
//   busy                     high whenever the FSM is not idle
//   error                    sticky timeout flag, cleared by the next job's first word
//   master_*                 Avalon-MM master port (word addresses)
//   done_irq                 slave DONE level
module euclid_host_master #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned VECTOR_SIZE   = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     error,
  output logic [ADDRESS_WIDTH-1:0] master_address,
  output logic                     master_read,
  input  logic [31:0]              master_readdata,
  output logic                     master_write,
  output logic [31:0]              master_writedata,
  input  logic                     master_waitrequest,
  input  logic                     done_irq
);

  localparam int unsigned NumWords = 4 * VECTOR_SIZE;
  localparam int unsigned IdxW     = $clog2(NumWords + 1);
  localparam int unsigned KW       = $clog2(VECTOR_SIZE + 1);
  localparam int unsigned CntW     = $clog2(TIMEOUT + 1);
  localparam logic [ADDRESS_WIDTH-1:0] ResBase = ADDRESS_WIDTH'(NumWords + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StKick, StWaitIrq, StSettle, StRead, StEmit, StClear
  } state_t;

  state_t            state;
  logic [IdxW-1:0]   idx;   // coordinate words already written
  logic [KW-1:0]     k;     // result currently being read/emitted
  logic [CntW-1:0]   cnt;   // shared timeout / settle counter

  logic              xfer_done;
  logic              last_word;
  logic              in_fire;
  logic [ADDRESS_WIDTH-1:0] next_addr;

  assign xfer_done = (master_write | master_read) & ~master_waitrequest;
  assign last_word = (idx == IdxW'(NumWords - 1));

  // The next word is accepted in the same cycle that the previous write completes. This keeps
  // the load at one word per cycle when the slave does not stall.
  assign in_ready = ~rst & ((state == StIdle) |
                            ((state == StLoad) & (~master_write | (xfer_done & ~last_word))));
  assign busy     = ~rst & (state != StIdle);
  assign in_fire  = in_valid & in_ready;

  // In LOAD, a write that is still pending while a word is accepted must be completing. The new
  // word then goes one slot further along.
  assign next_addr = ADDRESS_WIDTH'(idx) +
                     (master_write ? ADDRESS_WIDTH'(2) : ADDRESS_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= StClear;
      idx              <= '0;
      k                <= '0;
      cnt              <= '0;
      out_valid        <= 1'b0;
      out_data         <= '0;
      out_last         <= 1'b0;
      error            <= 1'b0;
      master_address   <= '0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_writedata <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_fire) begin
            master_writedata <= in_data;
            master_address   <= ADDRESS_WIDTH'(1);
            master_write     <= 1'b1;
            idx              <= '0;
            error            <= 1'b0;
            state            <= StLoad;
          end
        end

        StLoad: begin
          if (xfer_done) begin
            idx <= idx + IdxW'(1);
            if (last_word) begin
              // Write stays asserted; it becomes the CTRL=1 kick.
              master_address   <= '0;
              master_writedata <= 32'h1;
              state            <= StKick;
            end else begin
              master_write <= 1'b0;
            end
          end
          if (in_fire) begin
            master_writedata <= in_data;
            master_address   <= next_addr;
            master_write     <= 1'b1;
          end
        end

        StKick: begin
          if (xfer_done) begin
            master_write <= 1'b0;
            cnt          <= '0;
            state        <= StWaitIrq;
          end
        end

        StWaitIrq: begin
          if (done_irq) begin
            cnt   <= '0;
            state <= StSettle;
          end else if (cnt == CntW'(TIMEOUT)) begin
            error            <= 1'b1;
            master_write     <= 1'b1;
            master_address   <= '0;
            master_writedata <= 32'h0;
            state            <= StClear;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        StSettle: begin
          if (cnt == CntW'(SETTLE_CYCLES - 1)) begin
            k              <= '0;
            master_address <= ResBase;
            master_read    <= 1'b1;
            state          <= StRead;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        StRead: begin
          if (xfer_done) begin
            master_read <= 1'b0;
            out_data    <= master_readdata;
            out_valid   <= 1'b1;
            out_last    <= (k == KW'(VECTOR_SIZE - 1));
            state       <= StEmit;
          end
        end

        StEmit: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              master_write     <= 1'b1;
              master_address   <= '0;
              master_writedata <= 32'h0;
              state            <= StClear;
            end else begin
              k              <= k + KW'(1);
              master_address <= ResBase + ADDRESS_WIDTH'(k) + ADDRESS_WIDTH'(1);
              master_read    <= 1'b1;
              state          <= StRead;
            end
          end
        end

        StClear: begin
          if (xfer_done) begin
            master_write <= 1'b0;
            state        <= StIdle;
          end else if (!master_write) begin
            // Entered from reset with the strobe low, so launch the CTRL=0 write here.
            master_write     <= 1'b1;
            master_address   <= '0;
            master_writedata <= 32'h0;
          end
        end

        default: state <= StClear;
      endcase
    end
  end

endmodule
